// File: rtl/cond_unit_if.sv
// Bundle of the ALU-side handshake and the writeback-side payload used by
// the conditional-execution stage. The slave modport is the stage itself,
// the master modport is whoever drives the ALU side and sinks writeback.
interface cond_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       cond;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             reg_w;
    logic             mem_w;
    logic             pc_src;
    logic [3:0]       rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_rd;
    logic             out_reg_w;
    logic             out_mem_w;
    logic             out_pc_src;
    logic             out_cond_ex;

    modport slave (
        input  in_valid, cond, alu_result, alu_flags, flag_w,
               reg_w, mem_w, pc_src, rd, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd,
               out_reg_w, out_mem_w, out_pc_src, out_cond_ex
    );

    modport master (
        output in_valid, cond, alu_result, alu_flags, flag_w,
               reg_w, mem_w, pc_src, rd, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd,
               out_reg_w, out_mem_w, out_pc_src, out_cond_ex
    );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage that sits right after the ALU.
// It evaluates each instruction's condition field against the architectural
// NZCV register, commits flag updates only for instructions that execute,
// gates the writeback enables and keeps saturating executed/skipped counts.
// The single output register gives one cycle of latency and full throughput.
module cond_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cond_unit_if.slave       bus,
    output logic [3:0]       o_flags,
    output logic [CNT_W-1:0] o_cnt_exec,
    output logic [CNT_W-1:0] o_cnt_skip
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_outValid;
    logic [WIDTH-1:0] r_outResult;
    logic [3:0]       r_outRd;
    logic             r_outRegW;
    logic             r_outMemW;
    logic             r_outPcSrc;
    logic             r_outCondEx;
    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_cntExec;
    logic [CNT_W-1:0] r_cntSkip;

    logic             w_inReady;
    logic             w_acc;
    logic             w_condEx;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    assign w_inReady = ~r_outValid | bus.out_ready;
    assign w_acc     = bus.in_valid & w_inReady & ~bus.flush;

    // Decode the condition field against the committed flags; because the
    // flags register updates at the accepting edge, the next instruction
    // already sees the new values with no bubble.
    always_comb begin
        w_condEx = 1'b0;
        case (bus.cond)
            4'h0:    w_condEx = w_z;
            4'h1:    w_condEx = ~w_z;
            4'h2:    w_condEx = w_c;
            4'h3:    w_condEx = ~w_c;
            4'h4:    w_condEx = w_n;
            4'h5:    w_condEx = ~w_n;
            4'h6:    w_condEx = w_v;
            4'h7:    w_condEx = ~w_v;
            4'h8:    w_condEx = w_c & ~w_z;
            4'h9:    w_condEx = ~w_c | w_z;
            4'hA:    w_condEx = (w_n == w_v);
            4'hB:    w_condEx = (w_n != w_v);
            4'hC:    w_condEx = ~w_z & (w_n == w_v);
            4'hD:    w_condEx = w_z | (w_n != w_v);
            4'hE:    w_condEx = 1'b1;
            default: w_condEx = 1'b0;
        endcase
    end

    // Output valid bit: flush wins, a new accept keeps it set, and a
    // release with nothing arriving empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
        end else if (bus.flush) begin
            r_outValid <= 1'b0;
        end else if (w_acc) begin
            r_outValid <= 1'b1;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Payload only moves on accept, so it stays frozen while writeback stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outResult <= '0;
            r_outRd     <= '0;
            r_outRegW   <= 1'b0;
            r_outMemW   <= 1'b0;
            r_outPcSrc  <= 1'b0;
            r_outCondEx <= 1'b0;
        end else if (w_acc) begin
            r_outResult <= bus.alu_result;
            r_outRd     <= bus.rd;
            r_outRegW   <= bus.reg_w & w_condEx;
            r_outMemW   <= bus.mem_w & w_condEx;
            r_outPcSrc  <= bus.pc_src & w_condEx;
            r_outCondEx <= w_condEx;
        end
    end

    // Architectural flags change only for executed instructions, with the
    // N/Z and C/V halves enabled independently by the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (w_acc && w_condEx) begin
            if (bus.flag_w[1]) begin
                r_flags[3:2] <= bus.alu_flags[3:2];
            end
            if (bus.flag_w[0]) begin
                r_flags[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

    // Executed/skipped statistics stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntExec <= '0;
            r_cntSkip <= '0;
        end else if (w_acc) begin
            if (w_condEx) begin
                if (r_cntExec != CNT_MAX) begin
                    r_cntExec <= r_cntExec + CNT_ONE;
                end
            end else begin
                if (r_cntSkip != CNT_MAX) begin
                    r_cntSkip <= r_cntSkip + CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = r_outValid;
    assign bus.out_result  = r_outResult;
    assign bus.out_rd      = r_outRd;
    assign bus.out_reg_w   = r_outRegW;
    assign bus.out_mem_w   = r_outMemW;
    assign bus.out_pc_src  = r_outPcSrc;
    assign bus.out_cond_ex = r_outCondEx;
    assign o_flags         = r_flags;
    assign o_cnt_exec      = r_cntExec;
    assign o_cnt_skip      = r_cntSkip;

endmodule
